serial_keymatrix: RTL and testbench

//  Converts ASCII bytes from the serial keyboard receiver (uart_rx) into Galaksija key-matrix presses.

---
 rtl/serial_keymatrix_pkg.sv | 75 +++++++
 rtl/galkey_fifo.sv | 67 ++++++
 rtl/serial_keymatrix.sv | 136 +++++++++++++
 tb/tb_serial_keymatrix.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_keymatrix_pkg.sv
// Shared Galaksija key-matrix definitions: key indices, FSM states, FIFO entry
// layout and the ASCII-to-matrix mapping used at the FIFO input.
package serial_keymatrix_pkg;

   localparam logic [5:0] KEY_ENTER = 6'd48;
   localparam logic [5:0] KEY_LEFT  = 6'd29;
   localparam logic [5:0] KEY_BREAK = 6'd49;
   localparam logic [5:0] KEY_SPACE = 6'd31;
   localparam logic [5:0] KEY_SHIFT = 6'd53;

   localparam int ENTRY_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } km_state_t;

   typedef struct packed {
      logic       shift;
      logic [5:0] idx;
   } galentry_t;

   typedef struct packed {
      logic       valid;
      logic       shift;
      logic [5:0] idx;
   } galkey_t;

   function automatic galkey_t ascii_to_galkey(input logic [7:0] ch);
      galkey_t k;
      k       = '0;
      k.valid = 1'b1;
      if (ch >= 8'h41 && ch <= 8'h5A) begin
         k.idx = 6'(ch - 8'h40);
      end else if (ch >= 8'h61 && ch <= 8'h7A) begin
         k.idx = 6'(ch - 8'h60);
      end else if (ch >= 8'h30 && ch <= 8'h39) begin
         k.idx = 6'(ch - 8'h10);
      end else begin
         // Shifted row: _ ! " # $ % & \ ( ) + * < - > ? occupy 32..47 with SHIFT held
         case (ch)
            8'h0D, 8'h0A: k.idx = KEY_ENTER;
            8'h08, 8'h7F: k.idx = KEY_LEFT;
            8'h1B:        k.idx = KEY_BREAK;
            8'h20:        k.idx = KEY_SPACE;
            8'h5F: begin k.shift = 1'b1; k.idx = 6'd32; end
            8'h21: begin k.shift = 1'b1; k.idx = 6'd33; end
            8'h22: begin k.shift = 1'b1; k.idx = 6'd34; end
            8'h23: begin k.shift = 1'b1; k.idx = 6'd35; end
            8'h24: begin k.shift = 1'b1; k.idx = 6'd36; end
            8'h25: begin k.shift = 1'b1; k.idx = 6'd37; end
            8'h26: begin k.shift = 1'b1; k.idx = 6'd38; end
            8'h5C: begin k.shift = 1'b1; k.idx = 6'd39; end
            8'h28: begin k.shift = 1'b1; k.idx = 6'd40; end
            8'h29: begin k.shift = 1'b1; k.idx = 6'd41; end
            8'h2B: begin k.shift = 1'b1; k.idx = 6'd42; end
            8'h2A: begin k.shift = 1'b1; k.idx = 6'd43; end
            8'h3C: begin k.shift = 1'b1; k.idx = 6'd44; end
            8'h2D: begin k.shift = 1'b1; k.idx = 6'd45; end
            8'h3E: begin k.shift = 1'b1; k.idx = 6'd46; end
            8'h3F: begin k.shift = 1'b1; k.idx = 6'd47; end
            8'h3B: k.idx = 6'd42;
            8'h3A: k.idx = 6'd43;
            8'h2C: k.idx = 6'd44;
            8'h3D: k.idx = 6'd45;
            8'h2E: k.idx = 6'd46;
            8'h2F: k.idx = 6'd47;
            default: k.valid = 1'b0;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/galkey_fifo.sv
// Single-clock FIFO of pending key entries with synchronous clear.
module galkey_fifo
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 7
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // push is accepted when not full or when a pop frees a slot in the same cycle;
   // pop is ignored when empty; clear overrides both.
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !clear && (!full || pop);
   assign do_pop  = pop && !clear && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_keymatrix.sv
// Serial keyboard bytes to Galaksija key-matrix presses: each queued key is held
// for HOLD_CYCLES, then all keys are released for GAP_CYCLES.
module serial_keymatrix
   import serial_keymatrix_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int HOLD_CYCLES = 1000000,
   parameter int GAP_CYCLES  = 500000
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rd_key,
   input  logic [5:0]  key_addr,
   output logic [7:0]  key_out,
   output logic [63:0] keys,
   output logic        busy,
   output logic        ovf,
   output logic [1:0]  dbg_state
);

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   km_state_t        state;
   km_state_t        state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [63:0]      keys_n;

   galkey_t          dec;
   galentry_t        wr_entry;
   galentry_t        head;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   // Unmapped bytes never reach the FIFO, and flush discards the same-cycle byte.
   assign dec       = ascii_to_galkey(rx_data);
   assign wr_entry  = {dec.shift, dec.idx};
   assign fifo_push = rx_valid && dec.valid && !flush;
   assign ovf       = fifo_push && fifo_full && !fifo_pop;
   assign busy      = (state != ST_IDLE) || !fifo_empty;
   assign dbg_state = state;

   galkey_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         keys  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         keys  <= keys_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      keys_n   = keys;
      fifo_pop = 1'b0;
      if (flush) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         keys_n  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop            = 1'b1;
                  keys_n              = '0;
                  keys_n[head.idx]    = 1'b1;
                  if (head.shift) begin
                     keys_n[KEY_SHIFT] = 1'b1;
                  end
                  cnt_n   = HOLD_LOAD;
                  state_n = ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (cnt == '0) begin
                  keys_n  = '0;
                  cnt_n   = GAP_LOAD;
                  state_n = ST_GAP;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  state_n = ST_IDLE;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               keys_n  = '0;
            end
         endcase
      end
   end

   // CPU read port: one-cycle registered lookup, value held between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_out <= 8'hFF;
      end else if (rd_key) begin
         key_out <= keys[key_addr] ? 8'hFE : 8'hFF;
      end
   end

endmodule

// File: tb/tb_serial_keymatrix.sv
// Directed bench for serial_keymatrix with short hold/gap timing and a 4-deep FIFO.
module tb_serial_keymatrix;

   localparam int HOLD  = 8;
   localparam int GAP   = 4;
   localparam int DEPTH = 4;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        flush    = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rd_key   = 1'b0;
   logic [5:0]  key_addr = 6'd0;
   logic [7:0]  key_out;
   logic [63:0] keys;
   logic        busy;
   logic        ovf;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q[$];
   logic [7:0]  burst_bytes [6] = '{8'h41, 8'h42, 8'h31, 8'h0D, 8'h0A, 8'h58};

   always #5 clk = ~clk;

   serial_keymatrix #(
      .FIFO_DEPTH  (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rd_key    (rd_key),
      .key_addr  (key_addr),
      .key_out   (key_out),
      .keys      (keys),
      .busy      (busy),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b expected 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if (keys !== 64'd0) begin errors++; $display("FAIL reset_keys: got %h expected 0", keys); end
      checks++;
      if (key_out !== 8'hFF) begin errors++; $display("FAIL reset_key_out: got %h expected ff", key_out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      checks++;
      if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_key();
      send_byte(8'h61);
      checks++;
      if (keys !== 64'd0) begin errors++; $display("FAIL single_t1_keys: got %h expected 0", keys); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_t1_busy: got %b expected 1", busy); end
      for (int c = 2; c <= 9; c++) begin
         tick();
         checks++;
         if (keys !== 64'h2) begin
            errors++;
            $display("FAIL single_press_t%0d: keys=%h expected %h", c, keys, 64'h2);
         end
      end
      checks++;
      if (dbg_state !== 2'd1) begin errors++; $display("FAIL single_state_press: got %0d expected 1", dbg_state); end
      for (int c = 10; c <= 13; c++) begin
         tick();
         checks++;
         if (keys !== 64'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap_t%0d: keys=%h busy=%b expected 0/1", c, keys, busy);
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_t14_busy: got %b expected 0", busy); end
   endtask

   task automatic test_shifted_read();
      logic [63:0] exp;
      exp = (64'd1 << 47) | (64'd1 << 53);
      send_byte(8'h3F);
      tick();
      checks++;
      if (keys !== exp) begin errors++; $display("FAIL shifted_keys: got %h expected %h", keys, exp); end
      rd_key   = 1'b1;
      key_addr = 6'd47;
      tick();
      checks++;
      if (key_out !== 8'hFE) begin errors++; $display("FAIL read_addr47: got %h expected fe", key_out); end
      key_addr = 6'd5;
      tick();
      checks++;
      if (key_out !== 8'hFF) begin errors++; $display("FAIL read_addr5: got %h expected ff", key_out); end
      rd_key   = 1'b0;
      key_addr = 6'd47;
      tick();
      checks++;
      if (key_out !== 8'hFF) begin errors++; $display("FAIL read_hold: got %h expected ff", key_out); end
      for (int c = 6; c <= 9; c++) begin
         tick();
         checks++;
         if (keys !== exp) begin
            errors++;
            $display("FAIL shifted_hold_t%0d: keys=%h expected %h", c, keys, exp);
         end
      end
      tick();
      checks++;
      if (keys !== 64'd0) begin errors++; $display("FAIL shifted_release: got %h expected 0", keys); end
      wait_idle("shifted");
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      int          rel;
      int          k;
      exp_q.delete();
      exp_q.push_back(64'd1 << 1);
      exp_q.push_back(64'd1 << 2);
      exp_q.push_back(64'd1 << 33);
      exp_q.push_back(64'd1 << 48);
      exp_q.push_back(64'd1 << 48);
      for (int c = 0; c <= 72; c++) begin
         if (c < 6) begin
            rx_data  = burst_bytes[c];
            rx_valid = 1'b1;
         end else begin
            rx_valid = 1'b0;
         end
         #1;
         checks++;
         if (ovf !== (c == 5)) begin
            errors++;
            $display("FAIL burst_ovf_t%0d: got %b expected %b", c, ovf, (c == 5));
         end
         tick();
         rel = c + 1 - 2;
         k   = (rel >= 0) ? rel / 13 : 0;
         exp = 64'd0;
         if (rel >= 0 && k < exp_q.size() && (rel % 13) < HOLD) begin
            exp = exp_q[k];
         end
         checks++;
         if (keys !== exp) begin
            errors++;
            $display("FAIL burst_keys_t%0d: got %h expected %h", c + 1, keys, exp);
         end
      end
      rx_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL burst_done_busy: got %b expected 0", busy); end
   endtask

   task automatic test_unmapped();
      logic [7:0] bad [3];
      bad[0] = 8'h00;
      bad[1] = 8'h40;
      bad[2] = 8'h7E;
      for (int i = 0; i < 3; i++) begin
         rx_data  = bad[i];
         rx_valid = 1'b1;
         #1;
         checks++;
         if (ovf !== 1'b0) begin errors++; $display("FAIL unmapped_ovf_%0d: got %b expected 0", i, ovf); end
         tick();
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL unmapped_busy_%0d: got %b expected 0", i, busy); end
      end
      rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (keys !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_idle_%0d: keys=%h busy=%b expected 0/0", i, keys, busy);
         end
      end
   endtask

   task automatic test_flush();
      logic [63:0] seen;
      send_byte(8'h5A);
      tick();
      tick();
      tick();
      checks++;
      if (keys !== (64'd1 << 26)) begin errors++; $display("FAIL flush_pre_keys: got %h expected %h", keys, 64'd1 << 26); end
      flush    = 1'b1;
      rx_data  = 8'h35;
      rx_valid = 1'b1;
      #1;
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", ovf); end
      tick();
      flush    = 1'b0;
      rx_valid = 1'b0;
      checks++;
      if (keys !== 64'd0) begin errors++; $display("FAIL flush_keys: got %h expected 0", keys); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
      checks++;
      if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_state: got %0d expected 0", dbg_state); end
      seen = 64'd0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | keys;
      end
      checks++;
      if (seen !== 64'd0) begin errors++; $display("FAIL flush_no_press: seen %h expected 0", seen); end
   endtask

   task automatic test_async_reset();
      logic [63:0] seen;
      send_byte(8'h41);
      rx_data  = 8'h42;
      rx_valid = 1'b1;
      tick();
      rx_data  = 8'h43;
      tick();
      rx_valid = 1'b0;
      checks++;
      if (keys !== 64'h2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: keys=%h busy=%b expected 2/1", keys, busy);
      end
      rd_key   = 1'b1;
      key_addr = 6'd1;
      tick();
      rd_key   = 1'b0;
      checks++;
      if (key_out !== 8'hFE) begin errors++; $display("FAIL areset_pre_read: got %h expected fe", key_out); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (keys !== 64'd0) begin errors++; $display("FAIL areset_keys: got %h expected 0", keys); end
      checks++;
      if (key_out !== 8'hFF) begin errors++; $display("FAIL areset_key_out: got %h expected ff", key_out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
      checks++;
      if (dbg_state !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d expected 0", dbg_state); end
      #2;
      reset_n = 1'b1;
      seen = 64'd0;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen = seen | keys;
      end
      checks++;
      if (seen !== 64'd0) begin errors++; $display("FAIL areset_stale: seen %h expected 0", seen); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL areset_post_busy: got %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_shifted_read();
      test_back_to_back();
      test_unmapped();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
